// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| engine with two line buffers and a valid/ready pixel stream.
// Optional macro SOBEL_THRESH_EN: emit a binary edge map (mag >= THRESH) instead of saturation.
module sobel_stream #(
   parameter int unsigned IMG_W  = 64,
   parameter int unsigned IMG_H  = 64,
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned THRESH = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_last
);
   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned GW = PIX_W + 3;

   logic [CW-1:0]    col_q, col_d;
   logic [RW-1:0]    row_q, row_d;
   // Right two columns of the window: {top-l, top-r, mid-l, mid-r, bot-l, bot-r}
   logic [PIX_W-1:0] win_q [6];
   logic [PIX_W-1:0] win_d [6];
   logic [PIX_W-1:0] lb1_q [IMG_W];
   logic [PIX_W-1:0] lb2_q [IMG_W];

   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [PIX_W-1:0] out_pixel_q, out_pixel_d;

   logic             accept, gen, col_end, row_end;
   logic [PIX_W-1:0] ct, cm, cb;
   logic signed [GW-1:0] gx, gy;
   logic [GW-1:0]    ax, ay, mag;
   logic [PIX_W-1:0] res;

   function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] x);
      return $signed({3'b000, x});
   endfunction

   assign in_ready  = !out_valid_q || out_ready;
   assign out_valid = out_valid_q;
   assign out_pixel = out_pixel_q;
   assign out_last  = out_last_q;

   always_comb begin
      accept  = in_valid && in_ready;
      col_end = (col_q == CW'(IMG_W - 1));
      row_end = (row_q == RW'(IMG_H - 1));
      gen     = (row_q >= RW'(2)) && (col_q >= CW'(2));

      ct = lb2_q[col_q];
      cm = lb1_q[col_q];
      cb = in_pixel;

      // Window after this accept: P0..P8 = {win_q[0], win_q[1], ct, win_q[2], win_q[3], cm, ...}
      gx = (ext(ct) + (ext(cm) <<< 1) + ext(cb))
         - (ext(win_q[0]) + (ext(win_q[2]) <<< 1) + ext(win_q[4]));
      gy = (ext(win_q[4]) + (ext(win_q[5]) <<< 1) + ext(cb))
         - (ext(win_q[0]) + (ext(win_q[1]) <<< 1) + ext(ct));
      ax  = gx[GW-1] ? -gx : gx;
      ay  = gy[GW-1] ? -gy : gy;
      mag = ax + ay;

`ifdef SOBEL_THRESH_EN
      res = (mag >= GW'(THRESH)) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
      res = (mag[GW-1:PIX_W] != '0) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
`endif

      col_d = col_q;
      row_d = row_q;
      win_d = win_q;
      if (accept) begin
         win_d[0] = win_q[1];
         win_d[1] = ct;
         win_d[2] = win_q[3];
         win_d[3] = cm;
         win_d[4] = win_q[5];
         win_d[5] = cb;
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end

      out_valid_d = out_valid_q;
      out_pixel_d = out_pixel_q;
      out_last_d  = out_last_q;
      if (accept && gen) begin
         out_valid_d = 1'b1;
         out_pixel_d = res;
         out_last_d  = row_end && col_end;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_pixel_q <= '0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         out_valid_q <= out_valid_d;
         out_pixel_q <= out_pixel_d;
         out_last_q  <= out_last_d;
      end
   end

   // Line buffers carry no reset; stale contents never reach the output.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1_q[col_q] <= in_pixel;
         lb2_q[col_q] <= lb1_q[col_q];
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: directed frames plus random pixels/back-pressure against a
// whole-frame reference model.
module tb_sobel_stream;
   localparam int W = 8;
   localparam int H = 8;

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp); end end

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] in_pixel = 8'd0;
   logic       in_ready, out_valid, out_last;
   logic [7:0] out_pixel;

   sobel_stream #(
      .IMG_W (W),
      .IMG_H (H),
      .PIX_W (8),
      .THRESH(128)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_pixel (in_pixel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pixel(out_pixel),
      .out_last (out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int frame [H][W];
   int m_row = 0, m_col = 0;
   bit m_ov = 1'b0;
   int m_pix = 0;
   bit m_last = 1'b0;
   int n_out, n_last, n_hits, hit_val;

   // Reference: Sobel around centre (r,c) of the frame stored so far.
   function automatic int ref_pix(int r, int c);
      int gx, gy, mag;
      gx = (frame[r-1][c+1] + 2*frame[r][c+1] + frame[r+1][c+1])
         - (frame[r-1][c-1] + 2*frame[r][c-1] + frame[r+1][c-1]);
      gy = (frame[r+1][c-1] + 2*frame[r+1][c] + frame[r+1][c+1])
         - (frame[r-1][c-1] + 2*frame[r-1][c] + frame[r-1][c+1]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
      return (mag >= 128) ? 255 : 0;
`else
      return (mag > 255) ? 255 : mag;
`endif
   endfunction

   task automatic clear_stats(input int hv);
      n_out = 0;
      n_last = 0;
      n_hits = 0;
      hit_val = hv;
   endtask

   // One cycle: drive inputs after the falling edge, check, update the model for the rising edge.
   task automatic step(input bit v, input int px, input bit rdy, output bit acc);
      bit g;
      in_valid = v;
      in_pixel = px[7:0];
      out_ready = rdy;
      #1;
      `CHK("in_ready", in_ready, (!m_ov || rdy))
      `CHK("out_valid", out_valid, m_ov)
      if (m_ov) begin
         `CHK("out_pixel", out_pixel, m_pix[7:0])
         `CHK("out_last", out_last, m_last)
      end
      acc = v && (!m_ov || rdy);
      if (m_ov && rdy) begin
         n_out++;
         if (m_last) n_last++;
         if (m_pix == hit_val) n_hits++;
      end
      g = 1'b0;
      if (acc) begin
         frame[m_row][m_col] = px;
         if (m_row >= 2 && m_col >= 2) begin
            g = 1'b1;
            m_pix = ref_pix(m_row - 1, m_col - 1);
            m_last = (m_row == H - 1) && (m_col == W - 1);
         end
         if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
      if (g) m_ov = 1'b1;
      else if (rdy) m_ov = 1'b0;
      @(negedge clk);
   endtask

   // kind: 0 flat, 1 step edge, 2 ramp 10*col, 3 ramp 30*col, 4 random pixels with gaps
   task automatic feed_frame(input int kind, input int rdy_pct, input int npix);
      int px, tries;
      bit acc, v, rdy;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (r * W + c >= npix) return;
            case (kind)
               0: px = 100;
               1: px = (c < 4) ? 0 : 255;
               2: px = 10 * c;
               3: px = 30 * c;
               default: px = int'($urandom_range(255, 0));
            endcase
            tries = 0;
            acc = 1'b0;
            while (!acc) begin
               rdy = ($urandom_range(99, 0) < rdy_pct);
               v = (kind == 4) ? ($urandom_range(3, 0) != 0) : 1'b1;
               step(v, px, rdy, acc);
               tries++;
               if (!acc && tries > 200) begin
                  failures++;
                  $display("FAIL accept_timeout observed=blocked required=accept");
                  $fatal(1, "input stalled");
               end
            end
         end
      end
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, acc);
   endtask

`ifdef SOBEL_THRESH_EN
   localparam int Ramp10Exp = 0;
   localparam int Ramp30Exp = 255;
`else
   localparam int Ramp10Exp = 80;
   localparam int Ramp30Exp = 240;
`endif

   initial begin
      rst_n = 1'b0;
      #1;
      `CHK("rst_out_valid", out_valid, 1'b0)
      `CHK("rst_in_ready", in_ready, 1'b1)
      `CHK("rst_out_pixel", out_pixel, 8'd0)
      `CHK("rst_out_last", out_last, 1'b0)
      @(negedge clk);
      rst_n = 1'b1;

      clear_stats(0);
      feed_frame(0, 100, W * H);
      drain();
      `CHK("flat_count", n_out, 36)
      `CHK("flat_last", n_last, 1)
      `CHK("flat_zero", n_hits, 36)

      clear_stats(255);
      feed_frame(1, 100, W * H);
      drain();
      `CHK("step_count", n_out, 36)
      `CHK("step_edges", n_hits, 12)

      clear_stats(Ramp10Exp);
      feed_frame(2, 100, W * H);
      feed_frame(2, 100, W * H);
      drain();
      `CHK("ramp2_count", n_out, 72)
      `CHK("ramp2_last", n_last, 2)
      `CHK("ramp2_value", n_hits, 72)

      clear_stats(Ramp10Exp);
      feed_frame(2, 50, W * H);
      drain();
      `CHK("bp_count", n_out, 36)
      `CHK("bp_value", n_hits, 36)

      feed_frame(2, 100, 30);
      in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      `CHK("midrst_out_valid", out_valid, 1'b0)
      `CHK("midrst_in_ready", in_ready, 1'b1)
      `CHK("midrst_out_last", out_last, 1'b0)
      m_row = 0;
      m_col = 0;
      m_ov = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      `CHK("midrst_hold_valid", out_valid, 1'b0)
      rst_n = 1'b1;
      clear_stats(Ramp10Exp);
      feed_frame(2, 100, W * H);
      drain();
      `CHK("postrst_count", n_out, 36)
      `CHK("postrst_value", n_hits, 36)
      `CHK("postrst_last", n_last, 1)

      clear_stats(Ramp30Exp);
      feed_frame(3, 100, W * H);
      drain();
      `CHK("ramp30_value", n_hits, 36)

      clear_stats(-1);
      feed_frame(4, 60, W * H);
      feed_frame(4, 60, W * H);
      drain();
      `CHK("rand_count", n_out, 72)
      `CHK("rand_last", n_last, 2)

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
